// File: rtl/mux21_arb_pkg.sv
// Shared definitions for the two-requester packet arbiter: FSM encodings and beat counter width.
package mux21_arb_pkg;

   localparam int CNT_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      GNT1 = 2'd1,
      GNT2 = 2'd2
   } state_e;

endpackage

// File: rtl/mux21_arbiter_mux21.sv
// Single-bit 2:1 multiplexer; sel_i=0 passes a_i, sel_i=1 passes b_i.
module mux21 (
   input  logic a_i,
   input  logic b_i,
   input  logic sel_i,
   output logic y_o
);

   assign y_o = sel_i ? b_i : a_i;

endmodule

// File: rtl/mux21_arbiter.sv
// Packet-level arbiter between two requesters sharing one output channel, with round-robin
// tie-breaking, zero-latency data path and a beat-count watchdog.
module mux21_arbiter
   import mux21_arb_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int MAX_BEATS = 16
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             D1_VALID,
   input  logic [WIDTH-1:0] D1_DATA,
   input  logic             D1_LAST,
   output logic             D1_READY,
   input  logic             D2_VALID,
   input  logic [WIDTH-1:0] D2_DATA,
   input  logic             D2_LAST,
   output logic             D2_READY,
   output logic             Y_VALID,
   output logic [WIDTH-1:0] Y_DATA,
   output logic             Y_LAST,
   input  logic             Y_READY,
   output logic             S,
   output logic             TIMEOUT
);

   localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

   state_e           state_q, state_d;
   logic             pri_q, pri_d;       // 1: requester 2 was served last
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             timeout_q, timeout_d;
   logic             s_q, s_d;
   logic             last_mux;
   logic             xfer;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_data_mux
      mux21 u_mux21 (
         .a_i   (D1_DATA[gi]),
         .b_i   (D2_DATA[gi]),
         .sel_i (s_q),
         .y_o   (Y_DATA[gi])
      );
   end

   mux21 u_last_mux (
      .a_i   (D1_LAST),
      .b_i   (D2_LAST),
      .sel_i (s_q),
      .y_o   (last_mux)
   );

   assign Y_LAST  = last_mux & (state_q != IDLE);
   assign S       = s_q;
   assign TIMEOUT = timeout_q;

   always_comb begin
      state_d   = state_q;
      pri_d     = pri_q;
      cnt_d     = cnt_q;
      timeout_d = 1'b0;
      Y_VALID   = 1'b0;
      D1_READY  = 1'b0;
      D2_READY  = 1'b0;
      xfer      = 1'b0;

      case (state_q)
         IDLE: begin
            if (D1_VALID && (!D2_VALID || pri_q)) begin
               state_d = GNT1;
               cnt_d   = '0;
            end else if (D2_VALID) begin
               state_d = GNT2;
               cnt_d   = '0;
            end
         end
         GNT1: begin
            Y_VALID  = D1_VALID;
            D1_READY = Y_READY;
         end
         GNT2: begin
            Y_VALID  = D2_VALID;
            D2_READY = Y_READY;
         end
         default: state_d = IDLE;
      endcase

      xfer = Y_VALID & Y_READY;

      // Release on LAST, or forcibly when the watchdog limit is reached without LAST.
      if ((state_q != IDLE) && xfer) begin
         cnt_d = cnt_q + 1'b1;
         if (Y_LAST || ((cnt_q + 1'b1) == MAX_CNT)) begin
            state_d   = IDLE;
            pri_d     = (state_q == GNT2);
            timeout_d = ~Y_LAST;
         end
      end

      s_d = (state_d == GNT2);
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state_q   <= IDLE;
         pri_q     <= 1'b1;
         cnt_q     <= '0;
         timeout_q <= 1'b0;
         s_q       <= 1'b0;
      end else begin
         state_q   <= state_d;
         pri_q     <= pri_d;
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
         s_q       <= s_d;
      end
   end

endmodule

// File: doc/mux21_arbiter.md
MUX21_ARBITER -- requirements
Module: mux21_arbiter

Interface
REQ-001 Parameter WIDTH, default 8: data width of each requester and of the output channel.
REQ-002 Parameter MAX_BEATS, default 16: watchdog limit on beats per packet; legal range 2..255.
REQ-003 CLK  input  1  sole clock; all state updates on the rising edge.
REQ-004 RST_N  input  1  asynchronous, active-low reset.
REQ-005 D1_VALID  input  1  requester 1 has a beat.
REQ-006 D1_DATA  input  WIDTH  requester 1 beat data.
REQ-007 D1_LAST  input  1  requester 1 beat ends its packet.
REQ-008 D1_READY  output  1  requester 1 beat accepted this cycle when high with D1_VALID.
REQ-009 D2_VALID, D2_DATA, D2_LAST, D2_READY: same directions and widths as the D1 set, for requester 2.
REQ-010 Y_VALID  output  1  output beat valid.
REQ-011 Y_DATA  output  WIDTH  output beat data.
REQ-012 Y_LAST  output  1  output beat ends packet.
REQ-013 Y_READY  input  1  downstream accepts the beat.
REQ-014 S  output  1  current mux select; 0 selects requester 1, 1 selects requester 2.
REQ-015 TIMEOUT  output  1  one-cycle pulse when the watchdog forces a release.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, GNT1, GNT2.
REQ-017 In IDLE: Y_VALID=0; D1_READY=0; D2_READY=0.
REQ-018 IDLE transitions:
  - Only D1_VALID high -> GNT1 next cycle.
  - Only D2_VALID high -> GNT2 next cycle.
  - Both high -> grant the requester not served last (PRI register).
  - Neither high -> stay in IDLE.
REQ-019 In GNTn: Y_VALID, Y_DATA and Y_LAST equal the granted requester's signals combinationally (zero latency); Dn_READY=Y_READY; the other READY=0.
REQ-020 S SHALL be 1 in GNT2 and 0 otherwise; it is a registered state decode and never changes mid-packet.
REQ-021 A transfer SHALL occur when Y_VALID and Y_READY are both high; no other condition counts as a transfer.
REQ-022 Grant is held until a transfer with Y_LAST=1; the state then returns to IDLE, giving one bubble cycle between packets.
REQ-023 On grant release, PRI SHALL record the requester just served.
REQ-024 A granted requester dropping VALID mid-packet SHALL NOT release the grant.
REQ-025 A single-beat packet (LAST on its first beat) SHALL release the grant after that one beat.
REQ-026 The beat counter (8-bit) SHALL clear on entry to GNTn and increment per transfer.
REQ-027 Watchdog: a transfer that brings the count to MAX_BEATS with Y_LAST=0 SHALL force the return to IDLE, update PRI, and pulse TIMEOUT high for 1 cycle.
REQ-028 Outputs in the cycle of a forced release SHALL be identical to those of a normal in-grant transfer.

Reset
REQ-029 While RST_N=0: state=IDLE, PRI=requester 2 (so requester 1 wins the first tie), counter=0, S=0, TIMEOUT=0.
REQ-030 Reset asserted mid-packet SHALL abort the packet immediately (asynchronously), with no further READY to either requester.
REQ-031 After RST_N deasserts, the first grant SHALL be evaluated on the first rising CLK edge.

Structure
REQ-032 Shared package mux21_arb_pkg SHALL hold the state encodings (IDLE=2'd0, GNT1=2'd1, GNT2=2'd2) and the counter width constant.
REQ-033 The datapath SHALL instantiate the existing mux21 sub-module, one instance per bit via generate, for Y_DATA and one instance for Y_LAST, with S driving each select.
REQ-034 The FSM, PRI, counter and watchdog SHALL reside in this module; no other sub-modules are used.

Verification
REQ-035 Both VALID high after reset, 1-beat packets, Y_READY=1 -> grant order 1,2,1,2; S=0,1,0,1; one IDLE cycle between packets.
REQ-036 Requester 1 sends a 4-beat packet (data 0x11..0x14) while Y_READY is low on beats 2-3 -> Y_DATA holds each beat until accepted; S stays 0 throughout; D2_READY=0.
REQ-037 D1_VALID drops for 3 cycles mid-packet while D2_VALID=1 -> grant stays GNT1; requester 2 is served only after D1 LAST.
REQ-038 With MAX_BEATS=4, requester 2 streams 6 beats without LAST -> release after beat 4; TIMEOUT pulses for exactly 1 cycle; requester 1 granted next if valid.
REQ-039 RST_N pulled low on beat 2 of a requester-2 packet -> immediately S=0, Y_VALID=0, both READY=0; after release, requester 1 wins the next tie.
